mem_bus_arbiter: RTL

Shares the single 4-bit serial memory bus between the instruction-fetch requester and the load/store requester. It arbitrates between the two, then issues one command (address, size, direction) to the memory bus. It then serialises write data or assembles read data one nibble at a time, least-significant nibble first. It sits between the core's fetch/LSU stages and the external SPI/quad memory device.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/nibble_shifter.sv | 68 ++++++
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared size encodings, FSM state type and memory map constants.
// Revision: 1.0
// ============================================================================
package mem_pkg;

  localparam logic [1:0] MT_BYTE = 2'b01;
  localparam logic [1:0] MT_HALF = 2'b10;
  localparam logic [1:0] MT_WORD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [23:0] IM_START = 24'h000000;
  localparam logic [23:0] IM_STOP  = 24'h7FFFFF;
  localparam logic [23:0] DM_START = 24'h800000;
  localparam logic [23:0] DM_STOP  = 24'hFFFFFF;

  // Beats on the 4-bit bus per transfer size; anything unrecognised moves a word.
  function automatic logic [3:0] nib_total(input logic [1:0] size);
    case (size)
      MT_BYTE: return 4'd2;
      MT_HALF: return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_shifter.sv
`default_nettype none
// ============================================================================
// Module  : nibble_shifter
// Brief   : Nibble counter, write-nibble select and read assembly/extension.
// Revision: 1.0
// ============================================================================
module nibble_shifter
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_active,
  input  logic        i_we,
  input  logic [1:0]  i_type,
  input  logic        i_sext,
  input  logic [31:0] i_wdata,
  input  logic        i_wready,
  input  logic        i_rvalid,
  input  logic [3:0]  i_rnib,
  output logic [3:0]  o_wnib,
  output logic        o_last,
  output logic [31:0] o_rdata
);

  logic [2:0]  r_nib_cnt;
  logic [31:0] r_rbuf;
  logic [31:0] w_rbuf_next;
  logic [3:0]  w_total;
  logic        w_step;

  assign w_total = nib_total(i_type);
  assign w_step  = i_active & (i_we ? i_wready : i_rvalid);
  assign o_last  = w_step && ({1'b0, r_nib_cnt} == (w_total - 4'd1));
  assign o_wnib  = i_wdata[{r_nib_cnt, 2'b00} +: 4];

  always_comb begin
    w_rbuf_next = r_rbuf;
    if (w_step && !i_we)
      w_rbuf_next[{r_nib_cnt, 2'b00} +: 4] = i_rnib;
  end

  // Extension works on the buffer including the nibble arriving this cycle,
  // so the result can be registered on the same edge as the final beat.
  always_comb begin
    o_rdata = w_rbuf_next;
    case (i_type)
      MT_BYTE: o_rdata = {{24{i_sext & w_rbuf_next[7]}},  w_rbuf_next[7:0]};
      MT_HALF: o_rdata = {{16{i_sext & w_rbuf_next[15]}}, w_rbuf_next[15:0]};
      default: o_rdata = w_rbuf_next;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nib_cnt <= 3'd0;
      r_rbuf    <= 32'h0;
    end else if (!i_active) begin
      r_nib_cnt <= 3'd0;
      r_rbuf    <= 32'h0;
    end else begin
      if (w_step)
        r_nib_cnt <= r_nib_cnt + 3'd1;
      r_rbuf <= w_rbuf_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Fetch/load-store arbiter driving a 4-bit serial memory bus.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_done,
  output logic [31:0]       o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [1:0]        i_d_size,
  input  logic              i_d_sext,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  output logic              o_d_done,
  output logic [31:0]       o_d_rdata,
  output logic              o_mem_cmd_valid,
  input  logic              i_mem_cmd_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [1:0]        o_mem_type,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_wnib,
  output logic              o_mem_wvalid,
  input  logic              i_mem_wready,
  input  logic [3:0]        i_mem_rnib,
  input  logic              i_mem_rvalid
);

  localparam int                c_starve_w   = $clog2(STARVE_MAX + 2);
  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);

  state_t                  r_state, w_next;
  logic [c_starve_w-1:0]   r_starve;
  logic                    r_is_d, r_we, r_sext;
  logic [1:0]              r_type;
  logic [ADDR_W-1:0]       r_addr;
  logic [31:0]             r_wdata;
  logic                    r_if_done, r_d_done;
  logic [31:0]             r_if_rdata, r_d_rdata;
  logic                    w_grant_d, w_grant_i, w_active, w_last, w_fin;
  logic [3:0]              w_wnib;
  logic [31:0]             w_rdata;

  // Data normally wins; fetch is forced through once data has starved it.
  assign w_grant_d = i_d_req && !(i_if_req && (r_starve == c_starve_max));
  assign w_grant_i = i_if_req && !w_grant_d;
  assign w_active  = (r_state == S_XFER);
  assign w_fin     = w_active && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_if_req || i_d_req) w_next = S_CMD;
      S_CMD:  if (i_mem_cmd_ready)     w_next = S_XFER;
      S_XFER: if (w_last)              w_next = S_DONE;
      S_DONE:                          w_next = S_IDLE;
      default:                         w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve   <= '0;
      r_is_d     <= 1'b0;
      r_we       <= 1'b0;
      r_sext     <= 1'b0;
      r_type     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_if_rdata <= 32'h0;
      r_d_rdata  <= 32'h0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_grant_d) begin
          r_is_d  <= 1'b1;
          r_addr  <= i_d_addr;
          r_type  <= (i_d_size == 2'b00) ? MT_WORD : i_d_size;
          r_we    <= i_d_we;
          r_sext  <= i_d_sext & ~i_d_we;
          r_wdata <= i_d_wdata;
          if (!i_if_req)                  r_starve <= '0;
          else if (r_starve != c_starve_max) r_starve <= r_starve + 1'b1;
        end else if (w_grant_i) begin
          r_is_d   <= 1'b0;
          r_addr   <= i_if_addr;
          r_type   <= MT_WORD;
          r_we     <= 1'b0;
          r_sext   <= 1'b0;
          r_starve <= '0;
        end
      end
      r_if_done <= w_fin & ~r_is_d;
      r_d_done  <= w_fin & r_is_d;
      if (w_fin && !r_is_d)         r_if_rdata <= w_rdata;
      if (w_fin && r_is_d && !r_we) r_d_rdata  <= w_rdata;
    end
  end

  nibble_shifter u_nibble_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_active (w_active),
    .i_we     (r_we),
    .i_type   (r_type),
    .i_sext   (r_sext),
    .i_wdata  (r_wdata),
    .i_wready (i_mem_wready),
    .i_rvalid (i_mem_rvalid),
    .i_rnib   (i_mem_rnib),
    .o_wnib   (w_wnib),
    .o_last   (w_last),
    .o_rdata  (w_rdata)
  );

  assign o_mem_cmd_valid = (r_state == S_CMD);
  assign o_mem_addr      = r_addr;
  assign o_mem_type      = r_type;
  assign o_mem_we        = r_we;
  assign o_mem_wvalid    = w_active && r_we;
  assign o_mem_wnib      = o_mem_wvalid ? w_wnib : 4'h0;
  assign o_if_done       = r_if_done;
  assign o_if_rdata      = r_if_rdata;
  assign o_d_done        = r_d_done;
  assign o_d_rdata       = r_d_rdata;

endmodule
`default_nettype wire
